// File: rtl/hazard_forward_unit.sv
// Pipeline hazard unit: EX operand forwarding selects, load-use and
// multiply/divide scoreboard stall generation, saturating stall counter.
module hazard_forward_unit #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned MD_LAT  = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NUM_SRC*REG_AW-1:0]  EXsrc,
  input  logic [NUM_SRC*REG_AW-1:0]  IDsrc,
  input  logic [NUM_SRC-1:0]         IDuse,
  input  logic                       IDIsMD,
  input  logic                       EXMemRead,
  input  logic [REG_AW-1:0]          EXrd,
  input  logic                       EXMDStart,
  input  logic                       MemRegWrite,
  input  logic [REG_AW-1:0]          Memrd,
  input  logic                       WBRegWrite,
  input  logic [REG_AW-1:0]          WBrd,
  output logic [2*NUM_SRC-1:0]       FwdSel,
  output logic                       Stall,
  output logic                       Bubble,
  output logic                       MDBusy,
  output logic [CNT_W-1:0]           StallCount
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MD_WAIT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [3:0]        md_cnt_q, md_cnt_d;
  logic [REG_AW-1:0] md_rd_q, md_rd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic lu_hit;
  logic md_hit;

  always_comb begin
    logic [REG_AW-1:0] src;
    FwdSel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src = EXsrc[i*REG_AW +: REG_AW];
      if (MemRegWrite && (Memrd != '0) && (Memrd == src))
        FwdSel[2*i +: 2] = 2'd1;
      else if (WBRegWrite && (WBrd != '0) && (WBrd == src))
        FwdSel[2*i +: 2] = 2'd2;
    end
  end

  always_comb begin
    logic [REG_AW-1:0] src;
    lu_hit = 1'b0;
    md_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src = IDsrc[i*REG_AW +: REG_AW];
      if (IDuse[i] && (src == EXrd))
        lu_hit = 1'b1;
      if (IDuse[i] && (src == md_rd_q))
        md_hit = 1'b1;
    end
  end

  assign MDBusy     = (state_q == MD_WAIT);
  assign Stall      = (EXMemRead && (EXrd != '0) && lu_hit)
                    || (MDBusy && (IDIsMD || (md_hit && (md_rd_q != '0))));
  assign Bubble     = Stall;
  assign StallCount = stall_cnt_q;

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    md_rd_d  = md_rd_q;
    case (state_q)
      IDLE: begin
        if (EXMDStart) begin
          state_d  = MD_WAIT;
          md_cnt_d = 4'(MD_LAT - 1);
          md_rd_d  = EXrd;
        end
      end
      default: begin
        // A start in MD_WAIT only takes effect on the final cycle; earlier ones are dropped.
        if (md_cnt_q == 4'd0) begin
          if (EXMDStart) begin
            md_cnt_d = 4'(MD_LAT - 1);
            md_rd_d  = EXrd;
          end else begin
            state_d  = IDLE;
            md_rd_d  = '0;
          end
        end else begin
          md_cnt_d = md_cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      md_cnt_q    <= '0;
      md_rd_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      md_rd_q     <= md_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: a cycle-level reference model checked
// every cycle, plus hand-computed literal checks; second instance has a 4-bit counter.
module tb_hazard_forward_unit;

  localparam int AW  = 5;
  localparam int NS  = 2;
  localparam int LAT = 4;

  logic             Clk;
  logic             Reset;
  logic [NS*AW-1:0] EXsrc, IDsrc;
  logic [NS-1:0]    IDuse;
  logic             IDIsMD, EXMemRead, EXMDStart, MemRegWrite, WBRegWrite;
  logic [AW-1:0]    EXrd, Memrd, WBrd;

  logic [2*NS-1:0]  fwd_a, fwd_b;
  logic             stall_a, stall_b, bub_a, bub_b, busy_a, busy_b;
  logic [15:0]      cnt_a;
  logic [3:0]       cnt_b;

  int total = 0;
  int bad   = 0;

  hazard_forward_unit #(.REG_AW(AW), .NUM_SRC(NS), .MD_LAT(LAT), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .EXsrc(EXsrc), .IDsrc(IDsrc), .IDuse(IDuse),
    .IDIsMD(IDIsMD), .EXMemRead(EXMemRead), .EXrd(EXrd), .EXMDStart(EXMDStart),
    .MemRegWrite(MemRegWrite), .Memrd(Memrd), .WBRegWrite(WBRegWrite), .WBrd(WBrd),
    .FwdSel(fwd_a), .Stall(stall_a), .Bubble(bub_a), .MDBusy(busy_a), .StallCount(cnt_a)
  );

  hazard_forward_unit #(.REG_AW(AW), .NUM_SRC(NS), .MD_LAT(LAT), .CNT_W(4)) dut_sat (
    .Clk(Clk), .Reset(Reset), .EXsrc(EXsrc), .IDsrc(IDsrc), .IDuse(IDuse),
    .IDIsMD(IDIsMD), .EXMemRead(EXMemRead), .EXrd(EXrd), .EXMDStart(EXMDStart),
    .MemRegWrite(MemRegWrite), .Memrd(Memrd), .WBRegWrite(WBRegWrite), .WBrd(WBrd),
    .FwdSel(fwd_b), .Stall(stall_b), .Bubble(bub_b), .MDBusy(busy_b), .StallCount(cnt_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: remaining busy cycles of the multiply/divide, its target register,
  // and the two stall counts as plain integers.
  int m_busy = 0;
  int m_rd   = 0;
  int m_cnt  = 0;
  int m_cnt4 = 0;

  function automatic int field(input logic [NS*AW-1:0] v, input int i);
    return int'((v >> (i*AW)) % (1 << AW));
  endfunction

  function automatic int exp_fwd_op(input int i);
    int s;
    s = field(EXsrc, i);
    if (MemRegWrite && int'(Memrd) != 0 && int'(Memrd) == s) return 1;
    if (WBRegWrite && int'(WBrd) != 0 && int'(WBrd) == s) return 2;
    return 0;
  endfunction

  function automatic bit exp_stall();
    bit lu, mh;
    lu = 0;
    mh = 0;
    for (int i = 0; i < NS; i++) begin
      if (IDuse[i] && EXMemRead && int'(EXrd) != 0 && field(IDsrc, i) == int'(EXrd)) lu = 1;
      if (IDuse[i] && m_busy > 0 && m_rd != 0 && field(IDsrc, i) == m_rd) mh = 1;
    end
    if (m_busy > 0 && IDIsMD) mh = 1;
    return lu || mh;
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_busy = 0; m_rd = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      if (EXMDStart && m_busy > 1) begin
        bad++;
        $display("FAIL protocol: EXMDStart while busy, remaining=%0d required<=1", m_busy);
      end
      if (exp_stall()) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (m_busy <= 1) begin
        if (EXMDStart) begin
          m_busy = LAT; m_rd = int'(EXrd);
        end else begin
          m_busy = 0; m_rd = 0;
        end
      end else begin
        m_busy--;
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    int ef;
    bit es;
    es = exp_stall();
    for (int i = 0; i < NS; i++) begin
      ef = exp_fwd_op(i);
      chk($sformatf("model fwd[%0d]", i), int'(fwd_a[2*i +: 2]), ef);
      chk($sformatf("model fwd4[%0d]", i), int'(fwd_b[2*i +: 2]), ef);
    end
    chk("model stall", int'(stall_a), int'(es));
    chk("model bubble", int'(bub_a), int'(es));
    chk("model stall4", int'(stall_b), int'(es));
    chk("model busy", int'(busy_a), int'(m_busy > 0));
    chk("model busy4", int'(busy_b), int'(m_busy > 0));
    chk("model count", int'(cnt_a), m_cnt);
    chk("model count4", int'(cnt_b), m_cnt4);
  end

  task automatic clr();
    EXsrc = '0; IDsrc = '0; IDuse = '0; IDIsMD = 0; EXMemRead = 0; EXrd = '0;
    EXMDStart = 0; MemRegWrite = 0; Memrd = '0; WBRegWrite = 0; WBrd = '0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 0;
    #1;
    Reset = 1;
  endtask

  initial begin
    Reset = 0;
    clr();
    @(negedge Clk);
    chk("reset stall", int'(stall_a), 0);
    chk("reset busy", int'(busy_a), 0);
    chk("reset count", int'(cnt_a), 0);
    step();
    Reset = 1;

    // Forwarding priority
    Memrd = 5; WBrd = 5; MemRegWrite = 1; WBRegWrite = 1;
    EXsrc = {5'd6, 5'd5};
    @(negedge Clk);
    chk("fwd mem priority", int'(fwd_a), 4'b0001);
    step();
    MemRegWrite = 0;
    @(negedge Clk);
    chk("fwd wb only", int'(fwd_a), 4'b0010);
    step();
    MemRegWrite = 1; Memrd = 6;
    @(negedge Clk);
    chk("fwd both ops", int'(fwd_a), 4'b0110);
    step();

    // Register zero
    clr();
    MemRegWrite = 1; Memrd = 0; EXsrc = '0;
    EXMemRead = 1; EXrd = 0; IDuse = 2'b11; IDsrc = '0;
    @(negedge Clk);
    chk("zero fwd", int'(fwd_a), 0);
    chk("zero stall", int'(stall_a), 0);
    step();

    // Load-use
    clr();
    EXMemRead = 1; EXrd = 7; IDsrc = {5'd7, 5'd0}; IDuse = 2'b10;
    @(negedge Clk);
    chk("lu stall", int'(stall_a), 1);
    chk("lu bubble", int'(bub_a), 1);
    chk("lu count before", int'(cnt_a), 0);
    step();
    IDuse = 2'b01;
    @(negedge Clk);
    chk("lu count after", int'(cnt_a), 1);
    chk("lu unused op", int'(stall_a), 0);
    step();

    // MD scoreboard data hazard
    clr();
    pulse_reset();
    EXMDStart = 1; EXrd = 9;
    step();
    EXMDStart = 0; EXrd = 0; IDsrc = {5'd0, 5'd9}; IDuse = 2'b01;
    for (int k = 0; k < LAT; k++) begin
      @(negedge Clk);
      chk("md busy", int'(busy_a), 1);
      chk("md stall", int'(stall_a), 1);
      step();
    end
    @(negedge Clk);
    chk("md busy done", int'(busy_a), 0);
    chk("md stall done", int'(stall_a), 0);
    chk("md count", int'(cnt_a), 4);
    step();

    // Structural MD hazard, overlapping with a load-use
    clr();
    pulse_reset();
    EXMDStart = 1; EXrd = 3;
    step();
    EXMDStart = 0; IDIsMD = 1; EXMemRead = 1; EXrd = 11;
    IDsrc = {5'd11, 5'd3}; IDuse = 2'b11;
    for (int k = 0; k < LAT; k++) step();
    EXMemRead = 0;
    @(negedge Clk);
    chk("struct released", int'(stall_a), 0);
    chk("struct count", int'(cnt_a), 4);
    step();

    // Restart exactly on the final busy cycle
    clr();
    EXMDStart = 1; EXrd = 4;
    step();
    EXMDStart = 0;
    step(); step(); step();
    EXMDStart = 1; EXrd = 10;
    step();
    EXMDStart = 0;
    @(negedge Clk);
    chk("reload busy", int'(busy_a), 1);
    for (int k = 0; k < LAT; k++) step();
    @(negedge Clk);
    chk("reload done", int'(busy_a), 0);
    step();

    // Async reset mid-MD_WAIT
    clr();
    EXMDStart = 1; EXrd = 12;
    step();
    EXMDStart = 0; IDsrc = {5'd12, 5'd12}; IDuse = 2'b11;
    step();
    #2;
    Reset = 0;
    #1;
    chk("async busy", int'(busy_a), 0);
    chk("async stall", int'(stall_a), 0);
    chk("async count", int'(cnt_a), 0);
    chk("async count4", int'(cnt_b), 0);
    Reset = 1;
    step();

    // Saturation
    clr();
    EXMemRead = 1; EXrd = 7; IDsrc = {5'd7, 5'd7}; IDuse = 2'b11;
    for (int k = 0; k < 20; k++) step();
    chk("sat count4", int'(cnt_b), 15);
    chk("wide count", int'(cnt_a), 20);
    step();
    chk("sat hold", int'(cnt_b), 15);
    clr();
    step();
    @(negedge Clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
